triangle_scheduler: RTL and testbench

Front-end sequencer for `rasterizer_unit`. It accepts triangles over a valid/ready stream into a small FIFO and launches them one at a time on the rasterizer's `start`/`done` handshake. It holds each triangle's operands stable for the whole rasterization and reports per-frame completion. It sits between the vertex/transform stage and the single rasterizer instance.

---
 rtl/triangle_scheduler_pkg.sv | 23 ++
 rtl/triangle_scheduler_if.sv | 15 +
 rtl/triangle_scheduler_tri_fifo.sv | 49 ++++
 rtl/triangle_scheduler.sv | 135 +++++++++++++
 tb/tb_triangle_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/triangle_scheduler_pkg.sv
// Shared types for the triangle scheduler and the rasterizer it feeds:
// vertex/triangle records, scheduler FSM states and the FP 1.0 constant.
package raster_pkg;

  localparam logic [31:0] FP_ONE = 32'h3f800000;

  typedef logic [2:0][31:0] vertex_t;

  typedef struct packed {
    vertex_t    p1;
    vertex_t    p2;
    vertex_t    p3;
    logic [3:0] color;
  } tri_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_ARMED,
    S_RUN
  } sched_state_e;

endpackage

// File: rtl/triangle_scheduler_if.sv
// Valid/ready triangle stream from the vertex/transform stage into the scheduler.
interface triangle_scheduler_if;
  import raster_pkg::*;

  logic       in_valid;
  logic       in_ready;
  vertex_t    in_p1;
  vertex_t    in_p2;
  vertex_t    in_p3;
  logic [3:0] in_color;

  modport master (output in_valid, in_p1, in_p2, in_p3, in_color, input in_ready);
  modport slave  (input in_valid, in_p1, in_p2, in_p3, in_color, output in_ready);

endinterface

// File: rtl/triangle_scheduler_tri_fifo.sv
// Synchronous FIFO of triangles; pointers carry one extra wrap bit so
// full/empty fall out of the pointer difference.
module tri_fifo
  import raster_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     push,
  input  tri_t                     din,
  input  logic                     pop,
  output tri_t                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  tri_t          r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_push;
  logic          w_pop;

  assign count  = r_wr_ptr - r_rd_ptr;
  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  // A push is refused while full even if a pop happens in the same cycle.
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/triangle_scheduler.sv
// Queues triangles and launches them one at a time on the rasterizer start/done
// handshake. Optional watchdog abort is built when SCHED_WATCHDOG_EN is defined.
module triangle_scheduler
  import raster_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int WDOG_CYCLES = 1_000_000
) (
  input  logic                   clk,
  input  logic                   areset,
  triangle_scheduler_if.slave    s_in,
  input  logic                   frame_end,
  output logic                   ras_start,
  input  logic                   ras_done,
  output logic                   ras_reset,
  output vertex_t                ras_p1,
  output vertex_t                ras_p2,
  output vertex_t                ras_p3,
  output logic [3:0]             ras_color,
  output logic                   busy,
  output logic                   frame_done,
  output logic [15:0]            tri_count,
  output logic [7:0]             timeout_count
);

  sched_state_e               r_state;
  sched_state_e               w_state_nxt;
  tri_t                       w_din;
  tri_t                       w_head;
  tri_t                       r_op;
  logic                       w_full;
  logic                       w_empty;
  logic [$clog2(DEPTH):0]     w_count;
  logic                       w_pop;
  logic                       w_tri_done;
  logic                       w_expire;
  logic                       r_frame_pending;
  logic [15:0]                r_tri_count;

  assign w_din.p1    = s_in.in_p1;
  assign w_din.p2    = s_in.in_p2;
  assign w_din.p3    = s_in.in_p3;
  assign w_din.color = s_in.in_color;

  tri_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .areset(areset),
    .push  (s_in.in_valid),
    .din   (w_din),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign s_in.in_ready = !w_full;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_tri_done  = 1'b0;
    case (r_state)
      S_IDLE:  if (!w_empty && ras_done) begin
                 w_pop       = 1'b1;
                 w_state_nxt = S_ISSUE;
               end
      S_ISSUE: w_state_nxt = S_ARMED;
      S_ARMED: if (w_expire)       w_state_nxt = S_IDLE;
               else if (!ras_done) w_state_nxt = S_RUN;
      // Watchdog expiry wins over a done rise in the same cycle.
      S_RUN:   if (w_expire)       w_state_nxt = S_IDLE;
               else if (ras_done) begin
                 w_tri_done  = 1'b1;
                 w_state_nxt = S_IDLE;
               end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state         <= S_IDLE;
      r_op            <= '0;
      r_tri_count     <= '0;
      r_frame_pending <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop)      r_op        <= w_head;
      if (w_tri_done) r_tri_count <= r_tri_count + 16'd1;
      if (frame_end)       r_frame_pending <= 1'b1;
      else if (frame_done) r_frame_pending <= 1'b0;
    end
  end

  assign ras_start  = (r_state == S_ISSUE);
  assign ras_p1     = r_op.p1;
  assign ras_p2     = r_op.p2;
  assign ras_p3     = r_op.p3;
  assign ras_color  = r_op.color;
  assign busy       = (r_state != S_IDLE) || (w_count != '0);
  assign frame_done = r_frame_pending && (r_state == S_IDLE) && w_empty && ras_done;
  assign tri_count  = r_tri_count;

`ifdef SCHED_WATCHDOG_EN
  localparam int WDW = $clog2(WDOG_CYCLES + 1);

  logic [WDW-1:0] r_wdog;
  logic [7:0]     r_timeouts;
  logic           w_in_flight;

  assign w_in_flight = (r_state == S_ARMED) || (r_state == S_RUN);
  // Counter is 0 in the first ARMED cycle, so expiry lands WDOG_CYCLES after ISSUE.
  assign w_expire    = w_in_flight && (r_wdog == WDW'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_wdog     <= '0;
      r_timeouts <= '0;
    end else begin
      if (r_state == S_ISSUE) r_wdog <= '0;
      else if (w_in_flight)   r_wdog <= r_wdog + 1'b1;
      if (w_expire && (r_timeouts != 8'hFF)) r_timeouts <= r_timeouts + 8'd1;
    end
  end

  assign ras_reset     = w_expire;
  assign timeout_count = r_timeouts;
`else
  assign w_expire      = 1'b0;
  assign ras_reset     = 1'b0;
  assign timeout_count = '0;
`endif

endmodule

// File: tb/tb_triangle_scheduler.sv
// Scoreboard bench for triangle_scheduler: stimulus queues expected launches,
// a negedge monitor checks each ras_start against the queue.
module tb_triangle_scheduler;
  import raster_pkg::*;

  logic        clk = 1'b0;
  logic        areset = 1'b0;
  logic        frame_end = 1'b0;
  logic        ras_start, ras_reset, busy, frame_done, ras_done;
  vertex_t     ras_p1, ras_p2, ras_p3;
  logic [3:0]  ras_color;
  logic [15:0] tri_count;
  logic [7:0]  timeout_count;

  triangle_scheduler_if tif();

  triangle_scheduler #(.DEPTH(4), .WDOG_CYCLES(50)) dut (
    .clk          (clk),
    .areset       (areset),
    .s_in         (tif.slave),
    .frame_end    (frame_end),
    .ras_start    (ras_start),
    .ras_done     (ras_done),
    .ras_reset    (ras_reset),
    .ras_p1       (ras_p1),
    .ras_p2       (ras_p2),
    .ras_p3       (ras_p3),
    .ras_color    (ras_color),
    .busy         (busy),
    .frame_done   (frame_done),
    .tri_count    (tri_count),
    .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Rasterizer model: done drops after start, rises r_delay cycles later.
  logic m_done = 1'b1;
  int   m_cnt = 0;
  int   r_delay = 100;
  bit   force_busy = 1'b0;
  bit   stall = 1'b0;
  assign ras_done = m_done && !force_busy;

  always @(posedge clk) begin
    if (ras_start) begin
      m_done <= 1'b0;
      m_cnt  <= r_delay;
    end else if (ras_reset) begin
      m_done <= 1'b1;
    end else if (!m_done && !stall) begin
      if (m_cnt <= 1) m_done <= 1'b1;
      else            m_cnt  <= m_cnt - 1;
    end
  end

  typedef struct {
    tri_t t;
    int   acc;
    int   off;
    bit   gap;
  } exp_t;

  exp_t exp_q[$];
  tri_t held;
  bit   held_v = 1'b0;
  int   last_rise = -100;
  int   last_start = -100;
  int   n_start = 0;
  int   fd_cnt = 0;
  logic prev_done = 1'b1;

  // A cycle is numbered by the edge that closes it, hence cyc+1 for ras_start timing.
  always @(negedge clk) begin
    exp_t e;
    if (ras_start) begin
      n_start++;
      last_start = cyc;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL start_unexpected: got ras_start color %0h, expected no launch", ras_color);
      end else begin
        e = exp_q.pop_front();
        check("start_color", ras_color, e.t.color);
        check("start_p1", ras_p1, e.t.p1);
        check("start_p2", ras_p2, e.t.p2);
        check("start_p3", ras_p3, e.t.p3);
        if (e.off >= 0) check("start_cycle", cyc + 1, e.acc + e.off);
        if (e.gap)      check("start_gap", cyc - last_rise, 2);
        held.p1 = ras_p1; held.p2 = ras_p2; held.p3 = ras_p3; held.color = ras_color;
        held_v = 1'b1;
      end
    end
    if (ras_done && !prev_done) begin
      if (held_v) begin
        check("hold_ops", {ras_p1, ras_p2, ras_p3, ras_color}, held);
        held_v = 1'b0;
      end
      last_rise = cyc;
    end
    prev_done = ras_done;
    if (frame_done) fd_cnt++;
  end

  function automatic tri_t mk(input logic [31:0] x, input logic [3:0] c);
    tri_t t;
    t.p1    = {x, x ^ 32'h1, FP_ONE};
    t.p2    = {x + 32'h100, x, FP_ONE};
    t.p3    = {FP_ONE, x + 32'h200, x};
    t.color = c;
    return t;
  endfunction

  task automatic push_tri(input tri_t t, input int off, input bit gap);
    int n = 0;
    int acc;
    @(negedge clk);
    tif.in_valid = 1'b1;
    tif.in_p1 = t.p1; tif.in_p2 = t.p2; tif.in_p3 = t.p3; tif.in_color = t.color;
    while (!tif.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!tif.in_ready) begin
      total++;
      bad++;
      $display("FAIL push_timeout: in_ready stayed %0b, expected 1", tif.in_ready);
      tif.in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    acc = cyc;
    tif.in_valid = 1'b0;
    exp_q.push_back('{t: t, acc: acc, off: off, gap: gap});
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || !ras_done) && n < budget);
    if (busy || !ras_done) begin
      total++;
      bad++;
      $display("FAIL %s: busy=%0b ras_done=%0b after %0d cycles, expected idle", nm, busy, ras_done, budget);
    end
  endtask

  task automatic pulse_frame_end();
    @(negedge clk);
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n, fd0, s0;
    logic [15:0] tc0;
    logic [7:0]  to0;
    tif.in_valid = 1'b0;
    tif.in_p1 = '0; tif.in_p2 = '0; tif.in_p3 = '0; tif.in_color = '0;
    #1 areset = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_in_ready", tif.in_ready, 1'b1);
    check("rst_ras_start", ras_start, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_tri_count", tri_count, 16'd0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_ras_p1", ras_p1, '0);
    check("rst_timeout", timeout_count, 8'd0);
    areset = 1'b0;
    repeat (2) @(negedge clk);

    // Single triangle, 100-cycle rasterization, frame_end mid-run.
    r_delay = 100;
    push_tri(mk(32'h40000000, 4'h1), 2, 1'b0);
    repeat (9) @(negedge clk);
    fd0 = fd_cnt;
    pulse_frame_end();
    n = 0;
    while (tri_count != 16'd1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t1_tri_count", tri_count, 16'd1);
    check("t1_frame_done_cycle", frame_done, 1'b1);
    @(negedge clk);
    check("t1_frame_done_pulse", frame_done, 1'b0);
    check("t1_frame_done_count", fd_cnt - fd0, 1);
    wait_idle("t1_idle", 50);

    // Fill the queue with the rasterizer held busy, then drain.
    r_delay = 6;
    force_busy = 1'b1;
    for (int i = 0; i < 4; i++) push_tri(mk(32'h41000000 + 32'(i), 4'(i + 2)), -1, i > 0);
    check("fill_in_ready_low", tif.in_ready, 1'b0);
    @(negedge clk);
    tif.in_valid = 1'b1;
    tif.in_color = 4'hF;
    repeat (4) @(negedge clk);
    check("fill_fifth_held_off", tif.in_ready, 1'b0);
    tif.in_valid = 1'b0;
    s0 = n_start;
    force_busy = 1'b0;
    wait_idle("fill_drain", 400);
    check("fill_starts", n_start - s0, 4);
    check("fill_tri_count", tri_count, 16'd5);
    check("fill_queue_empty", exp_q.size(), 0);

    // Empty frame: frame_done the cycle after frame_end.
    fd0 = fd_cnt;
    pulse_frame_end();
    check("empty_frame_done", frame_done, 1'b1);
    @(negedge clk);
    check("empty_frame_once", fd_cnt - fd0, 1);

    // Two frame_end pulses in one busy frame merge into a single frame_done.
    r_delay = 20;
    fd0 = fd_cnt;
    push_tri(mk(32'h42000000, 4'h7), 2, 1'b0);
    pulse_frame_end();
    repeat (3) @(negedge clk);
    pulse_frame_end();
    check("merge_no_early_done", fd_cnt - fd0, 0);
    wait_idle("merge_drain", 200);
    repeat (3) @(negedge clk);
    check("merge_one_done", fd_cnt - fd0, 1);
    check("merge_tri_count", tri_count, 16'd6);

    // Reset while running with two triangles queued.
    r_delay = 100;
    push_tri(mk(32'h43000000, 4'h8), 2, 1'b0);
    push_tri(mk(32'h43000001, 4'h9), -1, 1'b0);
    push_tri(mk(32'h43000002, 4'hA), -1, 1'b0);
    repeat (6) @(negedge clk);
    check("rst_mid_busy_before", busy, 1'b1);
    areset = 1'b1;
    held_v = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mid_ras_start", ras_start, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_in_ready", tif.in_ready, 1'b1);
    check("rst_mid_tri_count", tri_count, 16'd0);
    check("rst_mid_color", ras_color, 4'h0);
    check("rst_mid_p2", ras_p2, '0);
    @(negedge clk);
    areset = 1'b0;
    s0 = n_start;
    repeat (30) @(negedge clk);
    check("rst_mid_no_start", n_start - s0, 0);
    check("rst_mid_in_ready_after", tif.in_ready, 1'b1);
    wait_idle("rst_mid_recover", 200);

    // tri_count wraps from 65535 to 0.
    force dut.r_tri_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_tri_count;
    r_delay = 4;
    push_tri(mk(32'h44000000, 4'hC), 2, 1'b0);
    wait_idle("wrap_drain", 100);
    check("wrap_zero", tri_count, 16'd0);

`ifdef SCHED_WATCHDOG_EN
    // Watchdog: rasterizer never finishes, each triangle aborted after 50 cycles.
    stall = 1'b1;
    tc0 = tri_count;
    to0 = timeout_count;
    push_tri(mk(32'h45000000, 4'hD), 2, 1'b0);
    push_tri(mk(32'h45000001, 4'hE), -1, 1'b0);
    n = 0;
    while (!ras_reset && n < 200) begin
      @(negedge clk);
      n++;
    end
    s0 = cyc;
    check("wd_reset_cycle", s0 - last_start, 50);
    @(negedge clk);
    check("wd_reset_pulse", ras_reset, 1'b0);
    check("wd_timeout_count", timeout_count, to0 + 8'd1);
    check("wd_tri_count", tri_count, tc0);
    n = 0;
    while (last_start <= s0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wd_next_start", last_start - s0, 2);
    n = 0;
    while (!ras_reset && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    stall = 1'b0;
    wait_idle("wd_drain", 100);
    check("wd_timeout_count2", timeout_count, to0 + 8'd2);
    check("wd_tri_count2", tri_count, tc0);
`else
    check("nowd_ras_reset", ras_reset, 1'b0);
    check("nowd_timeout", timeout_count, 8'd0);
`endif

    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
